vf_ramp_scheduler: RTL
======================

Name: vf_ramp_scheduler

Overview:
Sequences the PWM modulator of the inverter through start-up, frequency ramping, steady run, controlled stop and fault shutdown. It produces the reference-frequency command (sinusoid phase increment) and the modulation amplitude following a linear V/f law. It also produces the PWM enable and the bootstrap-precharge enable. Commands are shadow-loaded only at the carrier sync pulse from the PWM datapath, so carrier/reference comparison never sees a mid-period change.

Parameters:
FREQ_W, 16, width of frequency command (phase increment units)
AMP_W, 12, width of amplitude command; matches 12-bit carrier/reference
RAMP_DIV, 5000, clk_50 cycles per ramp tick (100 us)
FREQ_STEP, 4, frequency change per ramp tick
FREQ_MIN, 16, minimum running frequency; a smaller target is clamped up to it while running
BOOT_CYCLES, 50000, bootstrap precharge duration in clocks (1 ms)
VF_GAIN, 64, V/f slope; amplitude = BOOST + (freq*VF_GAIN)>>8
BOOST, 128, low-frequency voltage boost
AMP_MAX, 4095, amplitude saturation

Ports:
clk_50  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low
start  in  1  run request, level-sampled
stop  in  1  stop request, level-sampled
fault_in  in  1  hardware fault (overcurrent/desat), level
fault_clr  in  1  fault acknowledge, pulse
freq_target  in  FREQ_W  requested frequency
carrier_sync  in  1  one-clock pulse at carrier valley
freq_cmd  out  FREQ_W  shadowed frequency command to reference generator
amp_cmd  out  AMP_W  shadowed amplitude command
pwm_en  out  1  drivers enabled
boot_en  out  1  low-side on for bootstrap precharge
fault_latched  out  1  high while in FAULT
state  out  3  IDLE=0 BOOT=1 RAMP=2 RUN=3 STOPPING=4 FAULT=5

Behaviour:
- Reset when rst=0 at a clk_50 edge. All outputs go to 0, state=IDLE, internal freq_int=0, prescaler=0, boot counter=0.
- Request priority: fault_in > stop > start.
- IDLE: start=1, stop=0, fault_in=0 -> BOOT next cycle. Otherwise stay.
- BOOT:
  - boot_en=1 and pwm_en=0.
  - Counter runs 0..BOOT_CYCLES-1; on the terminal count -> RAMP, boot_en=0.
  - stop -> IDLE directly.
- RAMP and RUN:
  - pwm_en=1.
  - Effective target T = max(freq_target, FREQ_MIN).
  - Prescaler wraps at RAMP_DIV-1 and issues a tick. Prescaler is held at 0 in all other states.
  - On a tick, freq_int moves toward T by FREQ_STEP. If |T-freq_int| <= FREQ_STEP, freq_int lands exactly on T.
  - State = RUN when freq_int==T, RAMP otherwise. Target changes are re-evaluated on every tick, in either direction.
  - stop -> STOPPING.
- STOPPING:
  - Same tick mechanism, with target 0.
  - When freq_int==0 and freq_cmd==0 (shadow has loaded 0) -> IDLE, pwm_en=0 in the same transition.
  - start is ignored.
- FAULT:
  - fault_in=1 in any state -> FAULT next cycle.
  - On entry: pwm_en, boot_en, freq_cmd, amp_cmd and freq_int all cleared immediately, without waiting for carrier_sync.
  - fault_latched=1.
  - Exit to IDLE only on fault_clr=1 with fault_in=0. fault_clr while fault_in=1 is ignored.
- Amplitude law:
  - amp_int = 0 when freq_int==0.
  - Otherwise amp_int = min(BOOST + ((freq_int*VF_GAIN)>>8), AMP_MAX). The product is computed at FREQ_W+8 bits, with no overflow before saturation.
- Shadow load:
  - On carrier_sync=1 (and not in FAULT), freq_cmd<=freq_int and amp_cmd<=amp_int at the same edge.
  - If a tick coincides with carrier_sync, the shadow captures the pre-tick value.
  - Latency from tick to output = the next carrier_sync, plus 1 clock.
- start while in BOOT/RAMP/RUN/STOPPING is ignored. start=1 held through a completed stop re-enters BOOT from IDLE only after the stop has finished.
- Reset mid-operation: outputs cleared at that edge regardless of state. No shadow wait.

Test Plan:
Use bench parameters RAMP_DIV=4, BOOT_CYCLES=8, FREQ_STEP=4, FREQ_MIN=16, VF_GAIN=64, BOOST=128. Drive carrier_sync every 10 clocks.

1. Reset, then start pulse -> state=1 and boot_en=1 for exactly 8 clocks; then state=2, pwm_en=1, boot_en=0.
2. freq_target=40 -> freq_int steps 4,8,..,40 every 4 clocks; state=3 at 40. At the next carrier_sync: freq_cmd=40, amp_cmd=128+(40*64>>8)=138.
3. freq_target=42 while in RUN -> state=2, next tick lands on 42 exactly (step clipped), state=3. freq_target=5 -> ramps down to 16 (FREQ_MIN) and stays.
4. stop in RUN at freq 40 -> state=4, ramp to 0. pwm_en stays 1 until freq_cmd==0 is loaded at a carrier_sync; then state=0, pwm_en=0.
5. fault_in=1 during RAMP -> next cycle state=5, pwm_en=0, freq_cmd=0, amp_cmd=0, fault_latched=1. fault_clr with fault_in=1 -> stays in state 5. fault_in=0 then fault_clr -> state=0.
6. Edge cases:
   - start and stop together in IDLE -> stays in state 0.
   - freq_target=65535 with AMP_MAX=4095 -> amp_cmd saturates at 4095.
   - rst=0 during RUN -> all outputs 0 at that edge.

Source files
------------

// File: rtl/vf_ramp_scheduler.sv
// vf_ramp_scheduler
// Sequences the inverter PWM modulator: bootstrap precharge, frequency ramp,
// steady run, controlled stop and fault shutdown. Produces the reference
// frequency command (phase increment) and a V/f amplitude command, both
// shadow-loaded on the carrier valley so the modulator never sees a
// mid-period change.
//
// Ports:
//   clk_50         system clock (50 MHz)
//   rst            synchronous reset, active-low
//   start          run request (level)
//   stop           stop request (level)
//   fault_in       hardware fault (overcurrent/desat), level
//   fault_clr      fault acknowledge pulse
//   freq_target    requested frequency, phase-increment units
//   carrier_sync   one-clock pulse at the carrier valley
//   freq_cmd       shadowed frequency command
//   amp_cmd        shadowed amplitude command
//   pwm_en         gate drivers enabled
//   boot_en        low-side on for bootstrap precharge
//   fault_latched  high while in FAULT
//   state          current sequencer state
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | drivers off, waiting for start
// BOOT     | low-side on, charging bootstrap caps for BOOT_CYCLES
// RAMP     | drivers on, freq_int stepping toward the target
// RUN      | drivers on, freq_int equals the target
// STOPPING | drivers on, ramping to 0 until the shadow holds 0
// FAULT    | everything off, waiting for fault_clr with fault gone
module vf_ramp_scheduler #(
  parameter int unsigned FREQ_W      = 16,
  parameter int unsigned AMP_W       = 12,
  parameter int unsigned RAMP_DIV    = 5000,
  parameter int unsigned FREQ_STEP   = 4,
  parameter int unsigned FREQ_MIN    = 16,
  parameter int unsigned BOOT_CYCLES = 50000,
  parameter int unsigned VF_GAIN     = 64,
  parameter int unsigned BOOST       = 128,
  parameter int unsigned AMP_MAX     = 4095
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              fault_in,
  input  logic              fault_clr,
  input  logic [FREQ_W-1:0] freq_target,
  input  logic              carrier_sync,
  output logic [FREQ_W-1:0] freq_cmd,
  output logic [AMP_W-1:0]  amp_cmd,
  output logic              pwm_en,
  output logic              boot_en,
  output logic              fault_latched,
  output logic [2:0]        state
);

  localparam int unsigned PRESC_W = $clog2(RAMP_DIV + 1);
  localparam int unsigned BOOT_W  = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned PROD_W  = FREQ_W + 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BOOT     = 3'd1,
    S_RAMP     = 3'd2,
    S_RUN      = 3'd3,
    S_STOPPING = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [FREQ_W-1:0]   freq_int_q, freq_int_d;
  logic [FREQ_W-1:0]   freq_cmd_q, freq_cmd_d;
  logic [AMP_W-1:0]    amp_cmd_q, amp_cmd_d;

  logic                active;
  logic                tick;
  logic [FREQ_W-1:0]   run_target;
  logic [FREQ_W-1:0]   tick_target;
  logic [FREQ_W-1:0]   step_freq;
  logic [PROD_W-1:0]   vf_prod;
  logic [PROD_W-1:0]   vf_sum;
  logic [AMP_W-1:0]    amp_int;

  // Target, tick and one-step move toward the target
  always_comb begin
    run_target = (freq_target < FREQ_W'(FREQ_MIN)) ? FREQ_W'(FREQ_MIN) : freq_target;
    active     = (state_q == S_RAMP) || (state_q == S_RUN) || (state_q == S_STOPPING);
    tick       = active && (presc_q == PRESC_W'(RAMP_DIV - 1));
    tick_target = (state_q == S_STOPPING) ? '0 : run_target;

    step_freq = freq_int_q;
    if (freq_int_q < tick_target) begin
      if ((tick_target - freq_int_q) <= FREQ_W'(FREQ_STEP)) begin
        step_freq = tick_target;
      end else begin
        step_freq = freq_int_q + FREQ_W'(FREQ_STEP);
      end
    end else begin
      if ((freq_int_q - tick_target) <= FREQ_W'(FREQ_STEP)) begin
        step_freq = tick_target;
      end else begin
        step_freq = freq_int_q - FREQ_W'(FREQ_STEP);
      end
    end
  end

  // V/f law: widened product so the shift and boost cannot wrap before the clamp
  always_comb begin
    vf_prod = {8'd0, freq_int_q} * PROD_W'(VF_GAIN);
    vf_sum  = PROD_W'(BOOST) + (vf_prod >> 8);
    if (freq_int_q == '0) begin
      amp_int = '0;
    end else if (vf_sum > PROD_W'(AMP_MAX)) begin
      amp_int = AMP_W'(AMP_MAX);
    end else begin
      amp_int = vf_sum[AMP_W-1:0];
    end
  end

  // Next state, counters and shadow registers
  always_comb begin
    state_d    = state_q;
    freq_int_d = tick ? step_freq : freq_int_q;
    presc_d    = '0;
    boot_cnt_d = '0;
    freq_cmd_d = freq_cmd_q;
    amp_cmd_d  = amp_cmd_q;

    if (fault_in) begin
      state_d    = S_FAULT;
      freq_int_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) state_d = S_BOOT;
        end
        S_BOOT: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
            state_d = S_RAMP;
          end
        end
        S_RAMP, S_RUN: begin
          if (stop) begin
            state_d = S_STOPPING;
          end else begin
            state_d = (freq_int_d == run_target) ? S_RUN : S_RAMP;
          end
        end
        S_STOPPING: begin
          // Leave only once the modulator has actually been handed a zero command
          if ((freq_int_q == '0) && (freq_cmd_q == '0)) state_d = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Prescaler and boot counter restart from 0 on every entry
    if (active && ((state_d == S_RAMP) || (state_d == S_RUN) || (state_d == S_STOPPING))) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end
    if ((state_q == S_BOOT) && (state_d == S_BOOT)) begin
      boot_cnt_d = boot_cnt_q + BOOT_W'(1);
    end

    // Fault clears the shadow at once; otherwise load the pre-tick value at the valley
    if (fault_in) begin
      freq_cmd_d = '0;
      amp_cmd_d  = '0;
    end else if (carrier_sync && (state_q != S_FAULT)) begin
      freq_cmd_d = freq_int_q;
      amp_cmd_d  = amp_int;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      boot_cnt_q <= '0;
      freq_int_q <= '0;
      freq_cmd_q <= '0;
      amp_cmd_q  <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      boot_cnt_q <= boot_cnt_d;
      freq_int_q <= freq_int_d;
      freq_cmd_q <= freq_cmd_d;
      amp_cmd_q  <= amp_cmd_d;
    end
  end

  assign freq_cmd      = freq_cmd_q;
  assign amp_cmd       = amp_cmd_q;
  assign pwm_en        = active;
  assign boot_en       = (state_q == S_BOOT);
  assign fault_latched = (state_q == S_FAULT);
  assign state         = state_q;

endmodule
